// File: rtl/capture_sequencer_pkg.sv
// rtl/capture_sequencer_pkg.sv - shared camera capture types and buffer address width
package capture_sequencer_pkg;
  localparam int BUFFER_ADDRESS_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, DONE} capture_state_t;
endpackage

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - sequences one still capture into the image buffer, then serves SPI reads
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int BUFFER_SIZE        = 40000,
  parameter int ARM_TIMEOUT_CYCLES = 2880000
) (
  input  logic                            clock_in,
  input  logic                            reset_in,
  input  logic                            capture_request_in,
  input  logic                            abort_request_in,
  input  logic                            frame_valid_in,
  input  logic                            line_valid_in,
  input  logic                            read_advance_in,
  output logic                            buffer_write_enable_out,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_write_address_out,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_read_address_out,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] bytes_remaining_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            error_out
);
  localparam int AW = BUFFER_ADDRESS_WIDTH;
  localparam int TW = $clog2(ARM_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ARM_TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] BUF_LIMIT    = AW'(BUFFER_SIZE);

  capture_state_t r_state;
  logic           r_fv_prev;
  logic [AW-1:0]  r_write_count;
  logic [AW-1:0]  r_read_address;
  logic [AW-1:0]  r_write_address;
  logic [TW-1:0]  r_timeout;
  logic           r_write_enable;
  logic           r_error;
  logic           r_busy;
  logic           r_done;

  logic           w_rise;
  logic           w_fall;
  logic           w_pixel;
  logic           w_take;
  logic           w_arm;
  logic [AW-1:0]  w_remaining;

  assign w_rise      = frame_valid_in & ~r_fv_prev;
  assign w_fall      = ~frame_valid_in & r_fv_prev;
  assign w_pixel     = frame_valid_in & line_valid_in;
  // The rising-edge cycle itself already carries the first pixel of the frame.
  assign w_take      = ~abort_request_in &
                       (((r_state == ARMED) && w_rise) || (r_state == CAPTURING));
  assign w_arm       = ~abort_request_in & capture_request_in &
                       ((r_state == IDLE) || (r_state == DONE));
  assign w_remaining = r_write_count - r_read_address;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state         <= IDLE;
      r_fv_prev       <= 1'b0;
      r_write_count   <= '0;
      r_read_address  <= '0;
      r_write_address <= '0;
      r_timeout       <= '0;
      r_write_enable  <= 1'b0;
      r_error         <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_fv_prev      <= frame_valid_in;
      r_write_enable <= 1'b0;

      if (w_take && w_pixel) begin
        if (r_write_count < BUF_LIMIT) begin
          r_write_enable  <= 1'b1;
          r_write_address <= r_write_count;
          r_write_count   <= r_write_count + AW'(1);
        end else begin
          r_error <= 1'b1;
        end
      end

      if (abort_request_in) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_arm) begin
        r_state        <= ARMED;
        r_busy         <= 1'b1;
        r_done         <= 1'b0;
        r_write_count  <= '0;
        r_read_address <= '0;
        r_timeout      <= '0;
        r_error        <= 1'b0;
      end else begin
        case (r_state)
          ARMED: begin
            if (w_rise) begin
              r_state <= CAPTURING;
            end else if (r_timeout == TIMEOUT_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_timeout <= r_timeout + TW'(1);
            end
          end
          CAPTURING: begin
            if (w_fall) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          DONE: begin
            // Reads stop at the end of the capture rather than wrapping.
            if (read_advance_in && (w_remaining != '0)) begin
              r_read_address <= r_read_address + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign buffer_write_enable_out  = r_write_enable;
  assign buffer_write_address_out = r_write_address;
  assign buffer_read_address_out  = r_read_address;
  assign bytes_remaining_out      = r_done ? w_remaining : '0;
  assign busy_out                 = r_busy;
  assign done_out                 = r_done;
  assign error_out                = r_error;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - self-checking bench for capture_sequencer
module tb_capture_sequencer;
  localparam int BS  = 16;
  localparam int TMO = 100;
  localparam int P_IDLE = 0, P_ARMED = 1, P_CAPT = 2, P_DONE = 3;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        capture_request_in = 1'b0;
  logic        abort_request_in = 1'b0;
  logic        frame_valid_in = 1'b0;
  logic        line_valid_in = 1'b0;
  logic        read_advance_in = 1'b0;
  logic        we;
  logic [15:0] wa;
  logic [15:0] ra;
  logic [15:0] rem;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clock_in = ~clock_in;

  capture_sequencer #(.BUFFER_SIZE(BS), .ARM_TIMEOUT_CYCLES(TMO)) dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .capture_request_in      (capture_request_in),
    .abort_request_in        (abort_request_in),
    .frame_valid_in          (frame_valid_in),
    .line_valid_in           (line_valid_in),
    .read_advance_in         (read_advance_in),
    .buffer_write_enable_out (we),
    .buffer_write_address_out(wa),
    .buffer_read_address_out (ra),
    .bytes_remaining_out     (rem),
    .busy_out                (busy),
    .done_out                (done),
    .error_out               (err)
  );

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int first_wa = -1;

  // Reference model: mode, capture contents as a queue of written addresses, read position.
  int mode = P_IDLE;
  int cyc = 0;
  int arm_cyc = 0;
  int m_read = 0;
  int m_wa = 0;
  int m_we = 0;
  int m_err = 0;
  int m_prev = 0;
  int img[$];

  typedef struct {
    int rst, cap, ab, fv, lv, adv;
    int we, wa, busy, done, rem, err;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int rst, input int cap, input int ab,
                            input int fv, input int lv, input int adv);
    int rise, fall, take;
    cyc++;
    rise = (fv != 0 && m_prev == 0) ? 1 : 0;
    fall = (fv == 0 && m_prev != 0) ? 1 : 0;
    take = 0;
    m_we = 0;
    if (rst != 0) begin
      mode = P_IDLE; img.delete(); m_read = 0; m_wa = 0; m_err = 0; m_prev = 0;
    end else begin
      if (ab != 0) mode = P_IDLE;
      else if ((mode == P_IDLE || mode == P_DONE) && cap != 0) begin
        mode = P_ARMED; arm_cyc = cyc; img.delete(); m_read = 0; m_err = 0;
      end else if (mode == P_ARMED) begin
        if (rise != 0) begin mode = P_CAPT; take = 1; end
        else if (cyc - arm_cyc == TMO) begin mode = P_IDLE; m_err = 1; end
      end else if (mode == P_CAPT) begin
        take = 1;
        if (fall != 0) mode = P_DONE;
      end else if (mode == P_DONE && adv != 0 && m_read < img.size()) m_read++;
      if (take != 0 && fv != 0 && lv != 0) begin
        if (img.size() < BS) begin
          m_we = 1; m_wa = img.size(); img.push_back(m_wa);
        end else m_err = 1;
      end
      m_prev = fv;
    end
  endtask

  task automatic cycle(input int rst, input int cap, input int ab,
                       input int fv, input int lv, input int adv);
    int exp_rem;
    reset_in = (rst != 0);
    capture_request_in = (cap != 0);
    abort_request_in = (ab != 0);
    frame_valid_in = (fv != 0);
    line_valid_in = (lv != 0);
    read_advance_in = (adv != 0);
    @(posedge clock_in);
    model_step(rst, cap, ab, fv, lv, adv);
    @(negedge clock_in);
    if (we === 1'b1) begin
      if (n_writes == 0) first_wa = int'(wa);
      n_writes++;
    end
    exp_rem = (mode == P_DONE) ? img.size() - m_read : 0;
    chk("model_we", int'(we), m_we);
    if (m_we != 0) chk("model_waddr", int'(wa), m_wa);
    chk("model_raddr", int'(ra), m_read);
    chk("model_rem", int'(rem), exp_rem);
    chk("model_busy", int'(busy), (mode == P_ARMED || mode == P_CAPT) ? 1 : 0);
    chk("model_done", int'(done), (mode == P_DONE) ? 1 : 0);
    chk("model_err", int'(err), m_err);
  endtask

  task automatic frame(input int lines, input int ppl);
    cycle(0, 0, 0, 1, 0, 0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) cycle(0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 1, 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r_fv, r_lv, r_cap, r_ab, r_adv, r_rst;
    //          rst cap ab fv lv adv | we wa busy done rem err
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 0,  1, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 2, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};

    @(negedge clock_in);
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rst, tbl[i].cap, tbl[i].ab, tbl[i].fv, tbl[i].lv, tbl[i].adv);
      chk($sformatf("vec%0d_we", i), int'(we), tbl[i].we);
      chk($sformatf("vec%0d_waddr", i), int'(wa), tbl[i].wa);
      chk($sformatf("vec%0d_busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("vec%0d_done", i), int'(done), tbl[i].done);
      chk($sformatf("vec%0d_rem", i), int'(rem), tbl[i].rem);
      chk($sformatf("vec%0d_err", i), int'(err), tbl[i].err);
    end

    // Basic 3x4 capture and read-out, including the extra read pulse
    n_writes = 0; first_wa = -1;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    frame(3, 4);
    chk("basic_writes", n_writes, 12);
    chk("basic_first_addr", first_wa, 0);
    chk("basic_last_addr", int'(wa), 11);
    chk("basic_done", int'(done), 1);
    chk("basic_rem", int'(rem), 12);
    repeat (12) cycle(0, 0, 0, 0, 0, 1);
    chk("basic_rem_end", int'(rem), 0);
    chk("basic_raddr_end", int'(ra), 12);
    cycle(0, 0, 0, 0, 0, 1);
    chk("basic_rem_extra", int'(rem), 0);
    chk("basic_raddr_extra", int'(ra), 12);

    // Arm while a frame is already in progress
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    n_writes = 0; first_wa = -1;
    cycle(0, 1, 0, 1, 1, 0);
    repeat (4) cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("midarm_no_writes", n_writes, 0);
    chk("midarm_still_armed", int'(busy), 1);
    frame(2, 4);
    chk("midarm_writes", n_writes, 8);
    chk("midarm_first_addr", first_wa, 0);
    chk("midarm_rem", int'(rem), 8);

    // Overflow: 20 pixels into a 16-byte buffer
    n_writes = 0;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    frame(5, 4);
    chk("ovf_writes", n_writes, 16);
    chk("ovf_last_addr", int'(wa), 15);
    chk("ovf_err", int'(err), 1);
    chk("ovf_done", int'(done), 1);
    chk("ovf_rem", int'(rem), 16);

    // Arm timeout, then the next request clears the error
    n_writes = 0;
    cycle(0, 1, 0, 0, 0, 0);
    repeat (99) cycle(0, 0, 0, 0, 0, 0);
    chk("tmo_busy_before", int'(busy), 1);
    chk("tmo_err_before", int'(err), 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("tmo_busy_after", int'(busy), 0);
    chk("tmo_err_after", int'(err), 1);
    chk("tmo_writes", n_writes, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("tmo_err_cleared", int'(err), 0);
    cycle(0, 0, 1, 0, 0, 0);

    // Abort mid-capture after five writes
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_writes = 0;
    repeat (5) cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 1, 0);
    repeat (3) cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("abort_writes", n_writes, 5);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rem", int'(rem), 0);
    cycle(0, 1, 1, 0, 0, 0);
    chk("abort_cap_same_cycle", int'(busy), 0);

    // Reset mid-frame, then a clean capture
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 1, 1, 0);
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(wa), 0);
    chk("rst_raddr", int'(ra), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    repeat (2) cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_writes = 0; first_wa = -1;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    frame(2, 4);
    chk("rst_recap_writes", n_writes, 8);
    chk("rst_recap_first", first_wa, 0);
    chk("rst_recap_rem", int'(rem), 8);

    // Randomized traffic against the model
    r_fv = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) r_fv = 1 - r_fv;
      r_lv  = (r_fv != 0 && $urandom_range(0, 3) != 0) ? 1 : 0;
      r_cap = ($urandom_range(0, 19) == 0) ? 1 : 0;
      r_ab  = ($urandom_range(0, 79) == 0) ? 1 : 0;
      r_adv = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r_rst = ($urandom_range(0, 999) == 0) ? 1 : 0;
      cycle(r_rst, r_cap, r_ab, r_fv, r_lv, r_adv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
